// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor. It adds a WIDTH-bit pair CHUNK bits per clock
// and keeps a registered carry between chunks. Operands come in and results go
// out through valid/ready handshakes. The block reports carry-out and signed
// overflow.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK:0]   chk_res;
    logic             last_chk;
    logic             c_into_msb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the current chunk of both latched operands and add it with the running carry.
    always_comb begin
        a_chk = '0;
        b_chk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) begin
                a_chk = opa[k*CHUNK +: CHUNK];
                b_chk = opb[k*CHUNK +: CHUNK];
            end
        end
        chk_res  = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
        last_chk = (idx == IDXW'(NCHUNK - 1));
        // The sum bit is a^b^carry_in, so the carry into the MSB can be
        // recovered from the MSB sum bit and the MSB operand bits.
        c_into_msb = chk_res[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];
    end

    // Control FSM plus operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the +1 goes in through the carry.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IDXW'(k)) begin
                            sum[k*CHUNK +: CHUNK] <= chk_res[CHUNK-1:0];
                        end
                    end
                    carry <= chk_res[CHUNK];
                    if (last_chk) begin
                        cout  <= chk_res[CHUNK];
                        ovf   <= c_into_msb ^ chk_res[CHUNK];
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
